serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 busy  output  1  high while an addition is in progress (state RUN).
REQ-008 done  output  1  single-cycle pulse marking completion; sum and cout are valid from this cycle.
REQ-009 sum  output  WIDTH  registered result, equal to (a+b) mod 2^WIDTH.
REQ-010 cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL be an FSM with three states: IDLE, RUN and DONE.
REQ-012 start SHALL be accepted only when busy=0, i.e. in state IDLE or DONE.
REQ-013 On acceptance, the block SHALL capture a and b into shift registers, clear the carry flop, clear the bit counter and enter RUN.
REQ-014 In RUN, each clock edge SHALL process exactly one bit pair, LSB first:
- sum bit = a_bit ^ b_bit ^ carry;
- new carry = majority(a_bit, b_bit, carry);
- the sum bit shifts into the partial-result register from the MSB end;
- both operand registers shift right by one.
REQ-015 The bit counter SHALL count 0..WIDTH-1; on the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-016 On that same edge, sum SHALL load the completed partial result and cout SHALL load the final carry.
REQ-017 Latency SHALL be fixed: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH, with busy high for exactly WIDTH cycles.
REQ-018 done SHALL be high only in state DONE and SHALL last exactly one cycle.
REQ-019 From DONE, the FSM SHALL go to IDLE if start=0, or accept start directly and enter RUN (back-to-back operation, no idle cycle).
REQ-020 start asserted while in RUN SHALL be ignored; the operation in flight and its operand registers SHALL be unaffected.
REQ-021 Changes on a and b outside the acceptance edge SHALL have no effect.
REQ-022 sum and cout SHALL change only on the edge that enters DONE, and SHALL otherwise hold the last result, including throughout a subsequent RUN.
REQ-023 Carry SHALL never propagate between operations; each accepted start clears the carry.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL be held with: state=IDLE, busy=0, done=0, sum=0, cout=0, and carry, counter, operand and partial registers cleared.
REQ-025 Reset asserted during RUN SHALL abort the operation with no done pulse, and sum and cout SHALL read 0.
REQ-026 The first edge after rst deasserts SHALL be able to accept start.

Verification
REQ-027 The bench SHALL cover, with WIDTH=8, at minimum:
- Zero add: a=0x00, b=0x00, pulse start -> busy for 8 cycles, done pulse after edge k+8, sum=0x00, cout=0.
- Carry ripple: a=0xFF, b=0x01 -> sum=0x00, cout=1.
- Mixed operands and max case: a=0x5A, b=0x33 -> sum=0x8D, cout=0; then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Ignored start: start at bit 3 of a RUN with a=0x0F, b=0xF0 -> completes with sum=0xFF, cout=0 and exactly one done pulse, while the first result is held on sum until the second done.
- Reset mid-operation: rst asserted during RUN -> busy=0, done never pulses, sum=0x00, cout=0; the next start (a=0x01, b=0x01) -> sum=0x02.
- Back-to-back: start held high through the DONE cycle -> the new operation starts with no IDLE cycle, and its carry starts cleared after a cout=1 result.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start and added one bit pair per
// clock, LSB first. The result and carry are published together when the last bit is processed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             accept;
  logic             last_bit;
  logic             bit_sum;
  logic             bit_carry;

  // A new operation may start from IDLE or straight out of DONE, never mid-RUN.
  assign accept       = start && (state != RUN);
  assign last_bit     = (count == CW'(WIDTH - 1));
  assign bit_sum      = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_carry    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign partial_next = {bit_sum, partial[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // sum/cout are only written on the final bit, so they hold the previous result during a new RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      count   <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      partial <= '0;
      count   <= '0;
      carry   <= 1'b0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      partial <= partial_next;
      carry   <= bit_carry;
      count   <= count + CW'(1);
      if (last_bit) begin
        sum  <= partial_next;
        cout <= bit_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): each task drives one scenario
// and compares outputs against hand-computed values.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int WINDOW = WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests    = 0;
  int failures = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Called at a negedge; issues one start, scrambles a/b afterwards, and
  // observes a fixed window. Index 0 is the cycle right after the accept edge.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        output int busy_cnt, output int done_cnt, output int done_idx,
                        output logic [WIDTH-1:0] res, output logic res_c);
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    res      = '0;
    res_c    = 1'b0;
    a        = op_a;
    b        = op_b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~op_a;
    b     = op_b ^ 8'h5C;
    for (int i = 0; i < WINDOW; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i;
          res      = sum;
          res_c    = cout;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    tests++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL reset_sum: got %h want 00", sum); end
    tests++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout: got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_add();
    int bc, dc, di;
    logic [WIDTH-1:0] s;
    logic c;
    run_op(8'h00, 8'h00, bc, dc, di, s, c);
    tests++; if (bc != WIDTH) begin failures++; $display("[TB] FAIL zero_busy_cycles: got %0d want %0d", bc, WIDTH); end
    tests++; if (dc != 1) begin failures++; $display("[TB] FAIL zero_done_pulses: got %0d want 1", dc); end
    tests++; if (di != WIDTH) begin failures++; $display("[TB] FAIL zero_latency: got %0d want %0d", di, WIDTH); end
    tests++; if (s !== 8'h00) begin failures++; $display("[TB] FAIL zero_sum: got %h want 00", s); end
    tests++; if (c !== 1'b0) begin failures++; $display("[TB] FAIL zero_cout: got %b want 0", c); end
  endtask

  task automatic test_carry_ripple();
    int bc, dc, di;
    logic [WIDTH-1:0] s;
    logic c;
    run_op(8'hFF, 8'h01, bc, dc, di, s, c);
    tests++; if (di != WIDTH) begin failures++; $display("[TB] FAIL ripple_latency: got %0d want %0d", di, WIDTH); end
    tests++; if (s !== 8'h00) begin failures++; $display("[TB] FAIL ripple_sum: got %h want 00", s); end
    tests++; if (c !== 1'b1) begin failures++; $display("[TB] FAIL ripple_cout: got %b want 1", c); end
  endtask

  task automatic test_mixed_and_max();
    int bc, dc, di;
    logic [WIDTH-1:0] s;
    logic c;
    run_op(8'h5A, 8'h33, bc, dc, di, s, c);
    tests++; if (s !== 8'h8D) begin failures++; $display("[TB] FAIL mixed_sum: got %h want 8d", s); end
    tests++; if (c !== 1'b0) begin failures++; $display("[TB] FAIL mixed_cout: got %b want 0", c); end
    run_op(8'hFF, 8'hFF, bc, dc, di, s, c);
    tests++; if (bc != WIDTH) begin failures++; $display("[TB] FAIL max_busy_cycles: got %0d want %0d", bc, WIDTH); end
    tests++; if (s !== 8'hFE) begin failures++; $display("[TB] FAIL max_sum: got %h want fe", s); end
    tests++; if (c !== 1'b1) begin failures++; $display("[TB] FAIL max_cout: got %b want 1", c); end
  endtask

  // Previous result is FE/1; a stray start at bit 3 must neither restart nor disturb it.
  task automatic test_ignored_start();
    int dc = 0;
    int di = -1;
    int held_bad = 0;
    int late_busy = 0;
    logic [WIDTH-1:0] s = '0;
    logic c = 1'b0;
    a     = 8'h0F;
    b     = 8'hF0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < WINDOW + 4; i++) begin
      if (i == 3) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end else begin
        start = 1'b0;
      end
      if (busy && (sum !== 8'hFE || cout !== 1'b1)) held_bad++;
      if (done) begin
        dc++;
        if (di < 0) begin
          di = i;
          s  = sum;
          c  = cout;
        end
      end
      if (i > WIDTH && busy) late_busy++;
      @(negedge clk);
    end
    tests++; if (held_bad != 0) begin failures++; $display("[TB] FAIL ignored_held_result: got %0d disturbed cycles want 0", held_bad); end
    tests++; if (dc != 1) begin failures++; $display("[TB] FAIL ignored_done_pulses: got %0d want 1", dc); end
    tests++; if (di != WIDTH) begin failures++; $display("[TB] FAIL ignored_latency: got %0d want %0d", di, WIDTH); end
    tests++; if (s !== 8'hFF) begin failures++; $display("[TB] FAIL ignored_sum: got %h want ff", s); end
    tests++; if (c !== 1'b0) begin failures++; $display("[TB] FAIL ignored_cout: got %b want 0", c); end
    tests++; if (late_busy != 0) begin failures++; $display("[TB] FAIL ignored_restart: got %0d busy cycles after done want 0", late_busy); end
  endtask

  task automatic test_reset_mid_op();
    int bc, dc, di;
    logic [WIDTH-1:0] s;
    logic c;
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
    tests++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL midreset_sum: got %h want 00", sum); end
    tests++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cout: got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(8'h01, 8'h01, bc, dc, di, s, c);
    tests++; if (dc != 1) begin failures++; $display("[TB] FAIL postreset_done_pulses: got %0d want 1", dc); end
    tests++; if (di != WIDTH) begin failures++; $display("[TB] FAIL postreset_latency: got %0d want %0d", di, WIDTH); end
    tests++; if (s !== 8'h02) begin failures++; $display("[TB] FAIL postreset_sum: got %h want 02", s); end
    tests++; if (c !== 1'b0) begin failures++; $display("[TB] FAIL postreset_cout: got %b want 0", c); end
  endtask

  // First op ends with cout=1; the second is accepted from DONE, so a leaked carry would give 08.
  task automatic test_back_to_back();
    int dc = 0;
    int di = -1;
    int bc = 0;
    logic [WIDTH-1:0] s = '0;
    logic c = 1'b0;
    a     = 8'hFF;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH) @(negedge clk);
    tests++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done: got %b want 1", done); end
    tests++; if (sum !== 8'h00 || cout !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_result: got %h/%b want 00/1", sum, cout); end
    a     = 8'h03;
    b     = 8'h04;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hF0;
    b     = 8'h0F;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_idle: got busy=%b done=%b want busy=1 done=0", busy, done); end
    for (int i = 0; i < WINDOW; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (di < 0) begin
          di = i;
          s  = sum;
          c  = cout;
        end
      end
      @(negedge clk);
    end
    tests++; if (bc != WIDTH) begin failures++; $display("[TB] FAIL b2b_busy_cycles: got %0d want %0d", bc, WIDTH); end
    tests++; if (di != WIDTH) begin failures++; $display("[TB] FAIL b2b_latency: got %0d want %0d", di, WIDTH); end
    tests++; if (s !== 8'h07) begin failures++; $display("[TB] FAIL b2b_sum: got %h want 07", s); end
    tests++; if (c !== 1'b0) begin failures++; $display("[TB] FAIL b2b_cout: got %b want 0", c); end
  endtask

  initial begin
    test_reset();
    test_zero_add();
    test_carry_ripple();
    test_mixed_and_max();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
